// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control inputs and count/status outputs of the countdown timer
interface countdown_timer_if #(parameter int WIDTH = 7);
  logic             scaledclk;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] remaining;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             running;
  logic             done;
  logic             expired;
  modport master(
    output scaledclk, load, load_value, start, pause,
    input  remaining, tens, ones, running, done, expired
  );
  modport slave(
    input  scaledclk, load, load_value, start, pause,
    output remaining, tens, ones, running, done, expired
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: counts a loadable value down on scaledclk rising edges, flags expiry, shows BCD digits
module countdown_timer #(
  parameter int WIDTH     = 7,
  parameter int MAX_VALUE = 99
) (
  input logic              clock,
  input logic              reset,
  countdown_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VALUE);
  state_t           state, state_nx;
  logic             sc_q, tick, dec, exp_nx;
  logic [WIDTH-1:0] rem, rem_nx, sat, q10, r10;
  assign tick = bus.scaledclk & ~sc_q;
  assign sat  = bus.load_value > MAXV ? MAXV : bus.load_value;
  assign q10  = rem / WIDTH'(10);
  assign r10  = rem % WIDTH'(10);
  assign bus.remaining = rem;
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= '0;
      sc_q        <= 1'b0;
      bus.running <= 1'b0;
      bus.done    <= 1'b0;
      bus.expired <= 1'b0;
      bus.tens    <= '0;
      bus.ones    <= '0;
    end else begin
      state       <= state_nx;
      rem         <= rem_nx;
      sc_q        <= bus.scaledclk;
      bus.running <= state_nx == RUNNING;
      bus.done    <= state_nx == DONE;
      bus.expired <= exp_nx;
      bus.tens    <= q10[3:0];
      bus.ones    <= r10[3:0];
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (!bus.load && bus.start && rem != '0) ? RUNNING : IDLE;
      RUNNING: state_nx = bus.pause ? PAUSED : (tick && rem == WIDTH'(1)) ? DONE : RUNNING;
      PAUSED:  state_nx = bus.load ? IDLE : bus.start ? RUNNING : PAUSED;
      DONE:    state_nx = bus.load ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Loads are ignored only while running; pause wins over a same-cycle tick.
  always_comb begin
    dec    = state == RUNNING && !bus.pause && tick && rem != '0;
    exp_nx = dec && rem == WIDTH'(1);
    rem_nx = (bus.load && state != RUNNING) ? sat : dec ? rem - WIDTH'(1) : rem;
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scenarios plus randomized run against a behavioural model
module tb_countdown_timer;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  countdown_timer_if #(.WIDTH(7)) bus();
  countdown_timer #(.WIDTH(7), .MAX_VALUE(99)) dut(.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int total = 0, bad = 0;
  int m_rem = 0, m_mode = M_IDLE, m_tens = 0, m_ones = 0;
  bit m_sc = 1'b0, m_exp = 1'b0;

  task automatic cyc();
    int tn, on, lv;
    bit tk;
    tk = bus.scaledclk && !m_sc;
    tn = m_rem / 10;
    on = m_rem % 10;
    lv = bus.load_value > 99 ? 99 : int'(bus.load_value);
    m_exp = 1'b0;
    if (reset) begin
      m_rem = 0; m_mode = M_IDLE; m_sc = 1'b0; tn = 0; on = 0;
    end else begin
      m_sc = bus.scaledclk;
      case (m_mode)
        M_IDLE: if (bus.load) m_rem = lv; else if (bus.start && m_rem > 0) m_mode = M_RUN;
        M_RUN: begin
          if (bus.pause) m_mode = M_PAUSE;
          else if (tk && m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin m_mode = M_DONE; m_exp = 1'b1; end
          end
        end
        M_PAUSE: if (bus.load) begin m_rem = lv; m_mode = M_IDLE; end else if (bus.start) m_mode = M_RUN;
        default: if (bus.load) begin m_rem = lv; m_mode = M_IDLE; end
      endcase
    end
    m_tens = tn;
    m_ones = on;
    @(posedge clock);
    #1;
  endtask

  task automatic edge_sc();
    bus.scaledclk = 1'b1; cyc();
    bus.scaledclk = 1'b0; cyc();
  endtask

  task automatic do_load(input int v);
    bus.load_value = 7'(v); bus.load = 1'b1; cyc(); bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(); cyc();
    total++; if (bus.remaining !== 7'd0) begin bad++; $display("FAIL rst_rem got=%0d exp=0", bus.remaining); end
    total++; if ({bus.tens, bus.ones} !== 8'h00) begin bad++; $display("FAIL rst_bcd got=%h exp=00", {bus.tens, bus.ones}); end
    total++; if ({bus.running, bus.done, bus.expired} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {bus.running, bus.done, bus.expired}); end
    reset = 1'b0;
    do_load(5); do_start(); edge_sc(); edge_sc();
    total++; if (bus.remaining !== 7'd3 || bus.running !== 1'b1) begin bad++; $display("FAIL mid_count rem=%0d run=%b exp rem=3 run=1", bus.remaining, bus.running); end
    reset = 1'b1; cyc(); reset = 1'b0;
    total++; if ({bus.remaining, bus.tens, bus.ones, bus.running, bus.done, bus.expired} !== '0) begin bad++; $display("FAIL rst_mid got rem=%0d t=%0d o=%0d r=%b d=%b e=%b exp all 0", bus.remaining, bus.tens, bus.ones, bus.running, bus.done, bus.expired); end
    cyc();
    total++; if (bus.expired !== 1'b0 || bus.remaining !== 7'd0) begin bad++; $display("FAIL rst_after e=%b rem=%0d exp e=0 rem=0", bus.expired, bus.remaining); end
  endtask

  task automatic test_countdown();
    do_load(3); do_start();
    total++; if (bus.remaining !== 7'd3 || bus.running !== 1'b1) begin bad++; $display("FAIL cd_start rem=%0d run=%b exp 3/1", bus.remaining, bus.running); end
    for (int k = 2; k >= 0; k--) begin
      bus.scaledclk = 1'b1; cyc();
      total++; if (bus.remaining !== 7'(k)) begin bad++; $display("FAIL cd_rem got=%0d exp=%0d", bus.remaining, k); end
      total++; if (bus.expired !== (k == 0)) begin bad++; $display("FAIL cd_exp got=%b exp=%b", bus.expired, k == 0); end
      bus.scaledclk = 1'b0; cyc();
    end
    total++; if (bus.expired !== 1'b0 || bus.done !== 1'b1 || bus.running !== 1'b0) begin bad++; $display("FAIL cd_end e=%b d=%b r=%b exp 0/1/0", bus.expired, bus.done, bus.running); end
    total++; if ({bus.tens, bus.ones} !== 8'h00) begin bad++; $display("FAIL cd_bcd got=%h exp=00", {bus.tens, bus.ones}); end
  endtask

  task automatic test_saturation();
    do_load(120);
    total++; if (bus.remaining !== 7'd99) begin bad++; $display("FAIL sat_rem got=%0d exp=99", bus.remaining); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL sat_done got=%b exp=0", bus.done); end
    cyc();
    total++; if (bus.tens !== 4'd9 || bus.ones !== 4'd9) begin bad++; $display("FAIL sat_bcd got=%0d%0d exp=99", bus.tens, bus.ones); end
    do_load(47); cyc();
    total++; if (bus.tens !== 4'd4 || bus.ones !== 4'd7 || bus.remaining !== 7'd47) begin bad++; $display("FAIL bcd47 got=%0d%0d rem=%0d exp=47", bus.tens, bus.ones, bus.remaining); end
  endtask

  task automatic test_simultaneous();
    do_load(10); do_start();
    bus.pause = 1'b1; bus.scaledclk = 1'b1; cyc(); bus.pause = 1'b0; bus.scaledclk = 1'b0;
    total++; if (bus.remaining !== 7'd10 || bus.running !== 1'b0) begin bad++; $display("FAIL pause_tick rem=%0d run=%b exp 10/0", bus.remaining, bus.running); end
    cyc();
    bus.start = 1'b1; bus.scaledclk = 1'b1; cyc(); bus.start = 1'b0; bus.scaledclk = 1'b0;
    total++; if (bus.remaining !== 7'd10 || bus.running !== 1'b1) begin bad++; $display("FAIL start_tick rem=%0d run=%b exp 10/1", bus.remaining, bus.running); end
    cyc(); edge_sc();
    total++; if (bus.remaining !== 7'd9) begin bad++; $display("FAIL resume got=%0d exp=9", bus.remaining); end
  endtask

  task automatic test_ignored();
    do_load(8);
    total++; if (bus.remaining !== 7'd9 || bus.running !== 1'b1) begin bad++; $display("FAIL load_run rem=%0d run=%b exp 9/1", bus.remaining, bus.running); end
    reset = 1'b1; cyc(); reset = 1'b0;
    do_start();
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL start_zero run=%b exp=0", bus.running); end
    do_load(1); do_start(); edge_sc();
    do_start();
    total++; if (bus.done !== 1'b1 || bus.running !== 1'b0) begin bad++; $display("FAIL start_done d=%b r=%b exp 1/0", bus.done, bus.running); end
    do_load(2);
    total++; if (bus.done !== 1'b0 || bus.remaining !== 7'd2 || bus.running !== 1'b0) begin bad++; $display("FAIL reload d=%b rem=%0d r=%b exp 0/2/0", bus.done, bus.remaining, bus.running); end
  endtask

  task automatic test_tick_width();
    do_load(6); do_start();
    bus.scaledclk = 1'b1;
    repeat (50) cyc();
    total++; if (bus.remaining !== 7'd5) begin bad++; $display("FAIL tick_width got=%0d exp=5", bus.remaining); end
    bus.scaledclk = 1'b0; cyc();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      r = $urandom_range(0, 15);
      bus.load = (r < 2); bus.start = (r >= 2 && r < 5); bus.pause = (r == 5);
      bus.load_value = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 2) == 0) bus.scaledclk = ~bus.scaledclk;
      cyc();
      total++; if (bus.remaining !== 7'(m_rem)) begin bad++; $display("FAIL rand_rem n=%0d got=%0d exp=%0d", n, bus.remaining, m_rem); end
      total++; if (bus.tens !== 4'(m_tens) || bus.ones !== 4'(m_ones)) begin bad++; $display("FAIL rand_bcd n=%0d got=%0d/%0d exp=%0d/%0d", n, bus.tens, bus.ones, m_tens, m_ones); end
      total++; if (bus.running !== (m_mode == M_RUN) || bus.done !== (m_mode == M_DONE)) begin bad++; $display("FAIL rand_state n=%0d r=%b d=%b mode=%0d", n, bus.running, bus.done, m_mode); end
      total++; if (bus.expired !== m_exp) begin bad++; $display("FAIL rand_exp n=%0d got=%b exp=%b", n, bus.expired, m_exp); end
    end
    reset = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
  endtask

  initial begin
    bus.scaledclk = 1'b0; bus.load = 1'b0; bus.load_value = '0; bus.start = 1'b0; bus.pause = 1'b0;
    #1;
    test_reset();
    test_countdown();
    test_saturation();
    test_simultaneous();
    test_ignored();
    test_tick_width();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
